// File: rtl/vc_trace_pkg.sv
// Shared definitions for the line-trace monitor: ASCII constants, the
// per-channel handshake code, serializer states and character helpers.
package vc_trace_pkg;

   localparam logic [7:0] CH_PLUS  = 8'h2b;
   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_HASH  = 8'h23;
   localparam logic [7:0] CH_DOT   = 8'h2e;
   localparam logic [7:0] CH_COLON = 8'h3a;
   localparam logic [7:0] CH_BAR   = 8'h7c;
   localparam logic [7:0] CH_NL    = 8'h0a;

   // Channel code is {val, rdy} as sampled in the traced cycle.
   typedef logic [1:0] ch_code_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_STAMP,
      ST_SEP,
      ST_CHAN,
      ST_NL
   } ser_state_e;

   // Map a {val, rdy} code onto its trace character.
   function automatic logic [7:0] code_to_char(input ch_code_t code);
      case (code)
         2'b11:   return CH_PLUS;
         2'b01:   return CH_SPACE;
         2'b10:   return CH_HASH;
         default: return CH_DOT;
      endcase
   endfunction

   // Lowercase hex digit for one nibble of the cycle stamp.
   function automatic logic [7:0] nibble_to_hex(input logic [3:0] nib);
      if (nib < 4'd10)
         return 8'h30 + {4'h0, nib};
      else
         return 8'h57 + {4'h0, nib};
   endfunction

endpackage

// File: rtl/vc_trace_monitor_if.sv
// Byte-wide val/rdy character stream from the monitor to a UART/log sink.
interface vc_trace_monitor_if;

   logic [7:0] out_msg;
   logic       out_val;
   logic       out_rdy;

   modport master (output out_msg, output out_val, input out_rdy);
   modport slave  (input out_msg, input out_val, output out_rdy);

endinterface

// File: rtl/vc_trace_fifo.sv
// Synchronous entry buffer. A push into a full buffer is still taken when
// a pop happens in the same cycle, so occupancy stays unchanged. DEPTH is a
// power of two of at least 2 so the pointers wrap naturally.
module vc_trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW  = AW + 1;
   localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];

   // Storage array; contents need no reset because occupancy guards reads.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/vc_trace_monitor.sv
// Line-trace monitor: stamps the val/rdy state of NCHAN channels, buffers
// the entries and serializes each one as an ASCII line "cc: c|c|..\n".
module vc_trace_monitor
   import vc_trace_pkg::*;
#(
   parameter int NCHAN = 4,
   parameter int CYC_W = 16,
   parameter int DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  mode,
   input  logic [NCHAN-1:0]      chan_val,
   input  logic [NCHAN-1:0]      chan_rdy,
   vc_trace_monitor_if.master    trace,
   output logic                  ovf,
   output logic [15:0]           drop_cnt,
   output logic [CYC_W-1:0]      cycles
);

   localparam int CODE_W  = 2 * NCHAN;
   localparam int ENTRY_W = CYC_W + CODE_W;
   localparam logic [7:0] DIG_LAST = 8'(CYC_W / 4 - 1);
   localparam logic [7:0] SEG_LAST = 8'(2 * NCHAN - 2);

   logic [CODE_W-1:0]  cur_codes;
   logic [CODE_W-1:0]  last_codes;
   logic               record;
   logic               push_ok;
   logic               drop;
   logic               pop;
   logic               fire;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] fifo_rdata;
   logic [ENTRY_W-1:0] ser_entry;
   ser_state_e         state;
   logic [7:0]         idx;
   logic [7:0]         dig_pos;
   logic [CYC_W-1:0]   ser_stamp;
   logic [CODE_W-1:0]  ser_codes;
   logic [3:0]         nib;
   ch_code_t           ser_code;

   // Pack each channel's {val, rdy} into the current code vector.
   always_comb begin
      cur_codes = '0;
      for (int i = 0; i < NCHAN; i++)
         cur_codes[2*i +: 2] = {chan_val[i], chan_rdy[i]};
   end

   assign record  = en && (!mode || (|chan_val) || (cur_codes != last_codes));
   assign fire    = trace.out_val && trace.out_rdy;
   assign pop     = !fifo_empty && ((state == ST_IDLE) || ((state == ST_NL) && fire));
   assign push_ok = record && (!fifo_full || pop);
   assign drop    = record && !push_ok;

   vc_trace_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_ok),
      .pop   (pop),
      .wdata ({cycles, cur_codes}),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Free-running cycle stamp, wrapping modulo 2^CYC_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cycles <= '0;
      else
         cycles <= cycles + 1'b1;
   end

   // Compression reference: only entries actually buffered update it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_codes <= '0;
      else if (push_ok)
         last_codes <= cur_codes;
   end

   // Sticky overflow flag and saturating drop counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf      <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         ovf <= 1'b1;
         if (drop_cnt != 16'hffff)
            drop_cnt <= drop_cnt + 16'd1;
      end
   end

   // Serializer: walks stamp digits, ": ", channel codes and newline,
   // advancing only when the sink accepts a character.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         idx       <= '0;
         ser_entry <= '0;
      end else begin
         if (pop)
            ser_entry <= fifo_rdata;
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  state <= ST_STAMP;
                  idx   <= '0;
               end
            end
            ST_STAMP: begin
               if (fire) begin
                  if (idx == DIG_LAST) begin
                     state <= ST_SEP;
                     idx   <= '0;
                  end else begin
                     idx <= idx + 8'd1;
                  end
               end
            end
            ST_SEP: begin
               if (fire) begin
                  if (idx == 8'd1) begin
                     state <= ST_CHAN;
                     idx   <= '0;
                  end else begin
                     idx <= idx + 8'd1;
                  end
               end
            end
            ST_CHAN: begin
               if (fire) begin
                  if (idx == SEG_LAST) begin
                     state <= ST_NL;
                     idx   <= '0;
                  end else begin
                     idx <= idx + 8'd1;
                  end
               end
            end
            ST_NL: begin
               if (fire) begin
                  state <= pop ? ST_STAMP : ST_IDLE;
                  idx   <= '0;
               end
            end
            default: begin
               state <= ST_IDLE;
               idx   <= '0;
            end
         endcase
      end
   end

   assign ser_stamp = ser_entry[ENTRY_W-1 -: CYC_W];
   assign ser_codes = ser_entry[CODE_W-1:0];
   assign dig_pos   = DIG_LAST - idx;
   assign nib       = 4'(ser_stamp >> {dig_pos, 2'b00});
   assign ser_code  = 2'(ser_codes >> {idx[7:1], 1'b0});

   assign trace.out_val = (state != ST_IDLE);

   // Character currently offered to the sink; held while the state is held.
   always_comb begin
      trace.out_msg = 8'h00;
      case (state)
         ST_STAMP: trace.out_msg = nibble_to_hex(nib);
         ST_SEP:   trace.out_msg = (idx == 8'd0) ? CH_COLON : CH_SPACE;
         ST_CHAN:  trace.out_msg = idx[0] ? CH_BAR : code_to_char(ser_code);
         ST_NL:    trace.out_msg = CH_NL;
         default:  trace.out_msg = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_vc_trace_monitor.sv
// Self-checking bench for vc_trace_monitor with a string-level reference
// model of the buffered trace lines and the character stream.
module tb_vc_trace_monitor;

   localparam int NCHAN    = 2;
   localparam int CYC_W    = 8;
   localparam int DEPTH    = 2;
   localparam int LINE_LEN = CYC_W / 4 + 2 * NCHAN + 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              en = 1'b0;
   logic              mode = 1'b0;
   logic [NCHAN-1:0]  chan_val = '0;
   logic [NCHAN-1:0]  chan_rdy = '0;
   logic              ovf;
   logic [15:0]       drop_cnt;
   logic [CYC_W-1:0]  cycles;

   vc_trace_monitor_if trace_if ();

   vc_trace_monitor #(
      .NCHAN (NCHAN),
      .CYC_W (CYC_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .mode     (mode),
      .chan_val (chan_val),
      .chan_rdy (chan_rdy),
      .trace    (trace_if),
      .ovf      (ovf),
      .drop_cnt (drop_cnt),
      .cycles   (cycles)
   );

   always #5 clk = ~clk;

   int    checks = 0;
   int    errors = 0;

   string hexd = "0123456789abcdef";
   string buf_q[$];
   string cur_line;
   int    pos;
   bit    active;
   string last_codes;
   int    model_cyc;
   int    model_drops;
   bit    model_ovf;
   string obs_stream;
   int    first_fire_cyc;
   int    last_fire_cyc;

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkStr(input string tag, input string obs, input string exp);
      checks++;
      assert (obs == exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
      end
   endtask

   function automatic string chanChars(input logic [NCHAN-1:0] v, input logic [NCHAN-1:0] r);
      string s = "";
      for (int i = 0; i < NCHAN; i++) begin
         if (v[i] && r[i])  s = {s, "+"};
         else if (r[i])     s = {s, " "};
         else if (v[i])     s = {s, "#"};
         else               s = {s, "."};
      end
      return s;
   endfunction

   function automatic string fmtLine(input int stamp, input string codes);
      string s = "";
      for (int d = CYC_W / 4 - 1; d >= 0; d--)
         s = {s, $sformatf("%c", hexd[(stamp >> (4 * d)) & 15])};
      s = {s, ": "};
      for (int i = 0; i < NCHAN; i++) begin
         if (i > 0) s = {s, "|"};
         s = {s, $sformatf("%c", codes[i])};
      end
      s = {s, "\n"};
      return s;
   endfunction

   task automatic modelReset();
      buf_q.delete();
      cur_line    = "";
      pos         = 0;
      active      = 1'b0;
      last_codes  = chanChars('0, '0);
      model_cyc   = 0;
      model_drops = 0;
      model_ovf   = 1'b0;
   endtask

   // One traced cycle of the reference: what the sink sees, what is
   // recorded, whether it fits, and which line the serializer starts.
   task automatic modelStep(input bit e, input bit m, input logic [NCHAN-1:0] v,
                            input logic [NCHAN-1:0] r, input bit ordy);
      bit    fire;
      bit    pop;
      bit    rec;
      bit    accept;
      string codes;
      fire   = active && ordy;
      pop    = (buf_q.size() > 0) && (!active || (fire && pos == LINE_LEN - 1));
      codes  = chanChars(v, r);
      rec    = e && (!m || (|v) || (codes != last_codes));
      accept = rec && ((buf_q.size() < DEPTH) || pop);
      if (rec && !accept) begin
         model_ovf = 1'b1;
         if (model_drops < 65535) model_drops++;
      end
      if (fire) begin
         pos++;
         if (pos == LINE_LEN) active = 1'b0;
      end
      if (pop) begin
         cur_line = buf_q.pop_front();
         pos      = 0;
         active   = 1'b1;
      end
      if (accept) begin
         buf_q.push_back(fmtLine(model_cyc, codes));
         last_codes = codes;
      end
      model_cyc = (model_cyc + 1) % (1 << CYC_W);
   endtask

   task automatic checkOutput();
      logic [7:0] exp_msg;
      exp_msg = active ? cur_line[pos] : 8'h00;
      checkValue("out_val", trace_if.out_val, active);
      checkValue("out_msg", trace_if.out_msg, exp_msg);
      checkValue("cycles", cycles, model_cyc);
      checkValue("drop_cnt", drop_cnt, model_drops);
      checkValue("ovf", ovf, model_ovf);
   endtask

   // Drive one cycle's inputs, capture the accepted character, advance.
   task automatic applyStimulus(input bit e, input bit m, input logic [NCHAN-1:0] v,
                                input logic [NCHAN-1:0] r, input bit ordy);
      en              = e;
      mode            = m;
      chan_val        = v;
      chan_rdy        = r;
      trace_if.out_rdy = ordy;
      if (trace_if.out_val === 1'b1 && ordy) begin
         obs_stream = {obs_stream, $sformatf("%c", trace_if.out_msg)};
         if (first_fire_cyc < 0) first_fire_cyc = model_cyc;
         last_fire_cyc = model_cyc;
      end
      modelStep(e, m, v, r, ordy);
      @(posedge clk);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic startTest(input string name);
      $display("[TB] %s", name);
      rst_n            = 1'b0;
      en               = 1'b0;
      mode             = 1'b0;
      chan_val         = '0;
      chan_rdy         = '0;
      trace_if.out_rdy = 1'b0;
      modelReset();
      repeat (2) @(negedge clk);
      checkOutput();
      rst_n          = 1'b1;
      obs_stream     = "";
      first_fire_cyc = -1;
      last_fire_cyc  = -1;
   endtask

   initial begin
      int n;

      startTest("single line timing");
      repeat (3) applyStimulus(0, 0, 2'b00, 2'b00, 1);
      applyStimulus(1, 0, 2'b01, 2'b01, 1);
      repeat (12) applyStimulus(0, 0, 2'b00, 2'b00, 1);
      checkStr("line_03", obs_stream, "03: +|.\n");
      checkValue("first_char_cyc", first_fire_cyc, 5);
      checkValue("last_char_cyc", last_fire_cyc, 12);

      startTest("stall at colon");
      applyStimulus(1, 0, 2'b01, 2'b11, 1);
      n = 0;
      while (!(active && cur_line[pos] == 8'h3a) && n < 10) begin
         applyStimulus(0, 0, 2'b00, 2'b00, 1);
         n++;
      end
      checkValue("reach_colon", n < 10, 1);
      repeat (5) begin
         applyStimulus(0, 0, 2'b00, 2'b00, 0);
         checkValue("stall_msg", trace_if.out_msg, 8'h3a);
         checkValue("stall_val", trace_if.out_val, 1);
      end
      repeat (10) applyStimulus(0, 0, 2'b00, 2'b00, 1);
      checkStr("line_stall", obs_stream, "00: +| \n");

      startTest("overflow and drop accounting");
      repeat (5) applyStimulus(1, 0, 2'b00, 2'b00, 0);
      applyStimulus(0, 0, 2'b00, 2'b00, 0);
      checkValue("ovf_set", ovf, 1);
      checkValue("drop_two", drop_cnt, 2);
      repeat (30) applyStimulus(0, 0, 2'b00, 2'b00, 1);
      checkStr("drained_lines", obs_stream, "00: .|.\n01: .|.\n02: .|.\n");

      $display("[TB] reset in mid-line");
      obs_stream = "";
      applyStimulus(1, 0, 2'b11, 2'b00, 1);
      n = 0;
      while (obs_stream.len() < 2 && n < 20) begin
         applyStimulus(0, 0, 2'b00, 2'b00, 1);
         n++;
      end
      checkValue("reach_third_char", n < 20, 1);
      checkValue("pre_rst_drop", drop_cnt, 2);
      rst_n = 1'b0;
      #1;
      checkValue("rst_out_val", trace_if.out_val, 0);
      checkValue("rst_cycles", cycles, 0);
      checkValue("rst_drop_cnt", drop_cnt, 0);
      checkValue("rst_ovf", ovf, 0);
      modelReset();
      @(negedge clk);
      rst_n      = 1'b1;
      obs_stream = "";
      repeat (10) applyStimulus(0, 0, 2'b00, 2'b00, 1);
      checkStr("no_residue", obs_stream, "");

      startTest("compressed mode");
      repeat (10) applyStimulus(1, 1, 2'b00, 2'b00, 1);
      applyStimulus(1, 1, 2'b10, 2'b00, 1);
      repeat (22) applyStimulus(1, 1, 2'b00, 2'b00, 1);
      checkStr("compressed_lines", obs_stream, "0a: .|#\n0b: .|.\n");

      startTest("stamp wrap");
      repeat (260) applyStimulus(0, 0, 2'b00, 2'b00, 1);
      applyStimulus(1, 0, 2'b01, 2'b01, 1);
      repeat (12) applyStimulus(0, 0, 2'b00, 2'b00, 1);
      checkStr("wrapped_stamp", obs_stream, "04: +|.\n");

      startTest("random traffic");
      for (int i = 0; i < 600; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                       NCHAN'($urandom_range(0, 3)), NCHAN'($urandom_range(0, 3)),
                       $urandom_range(0, 2) != 0);
      end
      repeat (40) applyStimulus(0, 0, 2'b00, 2'b00, 1);
      checkValue("random_idle", trace_if.out_val, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
